// File: rtl/lookup_pkg.sv
// lookup_pkg: constants shared by the key packer and the lookup2 hash stage
package lookup_pkg;
    localparam int BLOCK_BYTES = 12;
    localparam int KEY_W       = 640;
    localparam logic FILL = 1'b0;
    localparam logic EMIT = 1'b1;
    localparam logic [31:0] GOLDEN_RATIO = 32'h9e3779b9;
    localparam logic [31:0] INIT_SEED    = 32'hdeadbeef;
endpackage

// File: rtl/key_packer.sv
// key_packer: packs a key byte stream into 96-bit k0/k1/k2 blocks for lookup2
// CLK, RST                               clock, synchronous active-high reset
// in_valid/in_ready/in_data/in_last      key byte stream
// out_enable/out_ready                   block handshake towards the hash stage
// out_key/out_last/out_idx/out_len       block, last flag, block index, key length
// err                                    sticky, a key exceeded MAX_BYTES
module key_packer
    import lookup_pkg::*;
#(
    parameter bit LITTLE_ENDIAN = 1'b0,
    parameter int MAX_BYTES     = 80,
    parameter int LEN_W         = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_enable,
    input  logic             out_ready,
    output logic [KEY_W-1:0] out_key,
    output logic             out_last,
    output logic [3:0]       out_idx,
    output logic [LEN_W-1:0] out_len,
    output logic             err
);
    localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_BYTES);
    localparam logic [3:0]       LAST_SLOT = 4'(BLOCK_BYTES - 1);
    if (LEN_W < $clog2(MAX_BYTES + 1)) begin : g_len_chk
        $error("key_packer: LEN_W too narrow for MAX_BYTES");
    end
    logic             state;
    logic [3:0]       slot;
    logic [3:0]       idx;
    logic [95:0]      blk;
    logic [95:0]      blk_nxt;
    logic [LEN_W-1:0] len;
    logic             last_r;
    logic             take;
    logic             done;
    assign in_ready   = state == FILL;
    assign take       = in_valid & in_ready;
    assign out_enable = state == EMIT;
    assign done       = out_enable & out_ready;
    assign out_key    = out_enable ? {{(KEY_W - 96){1'b0}}, blk} : '0;
    assign out_last   = out_enable & last_r;
    assign out_idx    = out_enable ? idx : 4'd0;
    assign out_len    = out_last ? len : '0;
    // Lane position: string order fills from bit 95 down; Jenkins order
    // puts byte 0 in the low byte of k0, byte 4 in the low byte of k1, ...
    for (genvar i = 0; i < BLOCK_BYTES; i++) begin : g_lane
        localparam int POS = LITTLE_ENDIAN ? 64 - 32 * (i / 4) + 8 * (i % 4) : 88 - 8 * i;
        assign blk_nxt[POS +: 8] = (take && slot == 4'(i)) ? in_data : blk[POS +: 8];
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= FILL;
            slot   <= 4'd0;
            blk    <= '0;
            len    <= '0;
            idx    <= 4'd0;
            err    <= 1'b0;
            last_r <= 1'b0;
        end else if (take) begin
            blk    <= blk_nxt;
            slot   <= slot + 4'd1;
            len    <= &len ? len : len + 1'b1;
            err    <= err | (len >= MAX_L);
            last_r <= in_last;
            if (in_last || slot == LAST_SLOT) state <= EMIT;
        end else if (done) begin
            state <= FILL;
            blk   <= '0;
            slot  <= 4'd0;
            idx   <= last_r ? 4'd0 : idx + 4'd1;
            if (last_r) len <= '0;
        end
    end
endmodule

// File: tb/tb_key_packer.sv
// tb_key_packer: scoreboard bench for key_packer in both byte orders
module tb_key_packer;
    typedef struct {
        logic [639:0] key;
        logic         last;
        logic [3:0]   idx;
        logic [15:0]  len;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iv   [2];
    logic         ir   [2];
    logic [7:0]   id   [2];
    logic         il   [2];
    logic         oe   [2];
    logic         ordy [2];
    logic [639:0] ok   [2];
    logic         ol   [2];
    logic [3:0]   ox   [2];
    logic [15:0]  on   [2];
    logic         er   [2];
    exp_t         exq0[$];
    exp_t         exq1[$];
    logic [7:0]   kb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    always #5 clk = ~clk;
    key_packer #(.LITTLE_ENDIAN(1'b0)) u_be (
        .CLK(clk), .RST(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .in_last(il[0]), .out_enable(oe[0]), .out_ready(ordy[0]), .out_key(ok[0]),
        .out_last(ol[0]), .out_idx(ox[0]), .out_len(on[0]), .err(er[0])
    );
    key_packer #(.LITTLE_ENDIAN(1'b1)) u_le (
        .CLK(clk), .RST(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .in_last(il[1]), .out_enable(oe[1]), .out_ready(ordy[1]), .out_key(ok[1]),
        .out_last(ol[1]), .out_idx(ox[1]), .out_len(on[1]), .err(er[1])
    );
    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic load(input string s);
        kb.delete();
        for (int i = 0; i < s.len(); i++) kb.push_back(s[i]);
    endtask
    task automatic push_model(input int sel);
        int   n;
        int   nb;
        exp_t e;
        logic [95:0] blk;
        logic [31:0] w;
        n  = kb.size();
        nb = (n + 11) / 12;
        for (int b = 0; b < nb; b++) begin
            blk = '0;
            for (int s = 0; s < 12; s++)
                if (b * 12 + s < n) blk[88 - 8 * s +: 8] = kb[b * 12 + s];
            if (sel == 1)
                for (int k = 0; k < 3; k++) begin
                    w = blk[32 * k +: 32];
                    blk[32 * k +: 32] = {w[7:0], w[15:8], w[23:16], w[31:24]};
                end
            e.key  = {544'b0, blk};
            e.last = (b == nb - 1);
            e.idx  = 4'(b);
            e.len  = e.last ? 16'(n) : 16'd0;
            if (sel == 0) exq0.push_back(e);
            else exq1.push_back(e);
        end
    endtask
    // drives kb onto one DUT; when is_key the final byte carries in_last
    task automatic run_key(input int sel, input bit is_key);
        int t;
        if (is_key) push_model(sel);
        for (int i = 0; i < kb.size(); i++) begin
            iv[sel] = 1'b1;
            id[sel] = kb[i];
            il[sel] = is_key && (i == kb.size() - 1);
            t = 0;
            while (!ir[sel] && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!ir[sel]) check("ready_timeout", 1, 0);
            @(negedge clk);
        end
        iv[sel] = 1'b0;
        il[sel] = 1'b0;
        if (is_key) check("enable_latency", oe[sel], 1);
    endtask
    task automatic drain(input int sel);
        int t = 0;
        while ((sel == 0 ? exq0.size() : exq1.size()) != 0 && t < 200) begin
            @(negedge clk);
            #3;
            t++;
        end
        check("drain", sel == 0 ? exq0.size() : exq1.size(), 0);
    endtask
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst) begin
            for (int s = 0; s < 2; s++)
                if (oe[s] && ordy[s]) begin
                    if ((s == 0 ? exq0.size() : exq1.size()) == 0) check("spurious_block", 1, 0);
                    else begin
                        e = (s == 0) ? exq0.pop_front() : exq1.pop_front();
                        check("key", ok[s], e.key);
                        check("last", ol[s], e.last);
                        check("idx", ox[s], e.idx);
                        check("len", on[s], e.len);
                    end
                end
        end
    end
    task automatic check_reset(input int sel);
        check("rst_enable", oe[sel], 0);
        check("rst_key", ok[sel], 0);
        check("rst_last", ol[sel], 0);
        check("rst_idx", ox[sel], 0);
        check("rst_len", on[sel], 0);
        check("rst_ready", ir[sel], 1);
        check("rst_err", er[sel], 0);
    endtask
    initial begin
        logic [639:0] stall_exp;
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0;
            id[s] = 8'h00;
            il[s] = 1'b0;
            ordy[s] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset(0);
        check_reset(1);
        load("abcdefghijkl");
        run_key(0, 1);
        drain(0);
        load("abcde");
        run_key(0, 1);
        check("c2_literal", ok[0], {544'b0, 96'h6162636465_00000000000000});
        drain(0);
        load("abcdefghijklm");
        run_key(0, 1);
        drain(0);
        ordy[0] = 1'b0;
        load("abc");
        run_key(0, 1);
        stall_exp = {544'b0, 24'h616263, 72'h0};
        iv[0] = 1'b1;
        id[0] = "p";
        for (int c = 0; c < 3; c++) begin
            check("stall_key", ok[0], stall_exp);
            check("stall_ready", ir[0], 0);
            check("stall_len", on[0], 3);
            @(negedge clk);
        end
        ordy[0] = 1'b1;
        drain(0);
        load("pq");
        run_key(0, 1);
        drain(0);
        load("1234567");
        run_key(0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset(0);
        repeat (2) @(negedge clk);
        check("no_pulse", oe[0], 0);
        load("xyz");
        run_key(0, 1);
        check("c5_literal", ok[0][95:72], 24'h78797a);
        drain(0);
        load("abcdefghijkl");
        run_key(1, 1);
        check("c6_literal", ok[1][95:0], 96'h64636261_68676665_6c6b6a69);
        drain(1);
        kb.delete();
        for (int i = 0; i < 81; i++) kb.push_back(8'(i + 1));
        run_key(1, 1);
        check("err_set", er[1], 1);
        check("err_other", er[0], 0);
        drain(1);
        load("q");
        run_key(1, 1);
        drain(1);
        check("err_sticky", er[1], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("err_cleared", er[1], 0);
        check_reset(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
